// File: rtl/jtag_scan_master_if.sv
// jtag_scan_master_if: command and response channel of the JTAG scan engine
interface jtag_scan_master_if #(
  parameter int MAX_BITS = 64
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [6:0]          cmd_len;
  logic [MAX_BITS-1:0] cmd_tdi;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_tdo;
  logic                busy;
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_tdi,
    input  cmd_ready, rsp_valid, rsp_tdo, busy
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_tdi,
    output cmd_ready, rsp_valid, rsp_tdo, busy
  );
endinterface

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: JTAG host engine issuing clocked resets and IR/DR scans from a command channel
module jtag_scan_master #(
  parameter int IR_LENGTH = 4,
  parameter int MAX_BITS  = 64,
  parameter int TCK_DIV   = 2
) (
  input  logic              clk,
  input  logic              reset,
  jtag_scan_master_if.slave bus,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);
  localparam int DW = $clog2(TCK_DIV + 1);
  typedef enum logic [1:0] {RESET_SEQ, IDLE, RUN, DONE} state_t;
  state_t              st;
  logic [DW-1:0]       div;
  logic [7:0]          pcnt, k;
  logic [1:0]          op;
  logic [6:0]          len;
  logic                auto_seq;
  logic [MAX_BITS-1:0] dat, cap;
  logic                ir_op, sh_cur, sh_nxt, tms_nxt, tdi_nxt, accept;
  logic [7:0]          pre, nl, q, pi, qi;
  logic [6:0]          clen;
  assign bus.cmd_ready = st == IDLE || st == DONE;
  assign bus.busy = ~bus.cmd_ready;
  always_comb begin
    ir_op   = op == 2'd1;
    pre     = ir_op ? 8'd4 : 8'd3;
    nl      = ir_op ? 8'(IR_LENGTH) : {1'b0, len};
    q       = pcnt + 8'd1;
    pi      = pcnt - pre;
    qi      = q - pre;
    sh_cur  = op != 2'd0 && pcnt >= pre && pcnt < pre + nl;
    sh_nxt  = op != 2'd0 && q >= pre && q < pre + nl;
    tms_nxt = op == 2'd0 ? q < 8'd5
            : q < (ir_op ? 8'd2 : 8'd1) || q == pre + nl - 8'd1 || q == pre + nl;
    tdi_nxt = sh_nxt && |(dat & (MAX_BITS'(1'b1) << qi));
    clen    = bus.cmd_len > 7'(MAX_BITS) ? 7'(MAX_BITS) : bus.cmd_len;
    accept  = bus.cmd_valid && bus.cmd_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= RESET_SEQ;
      tck           <= 1'b0;
      tms           <= 1'b1;
      tdi           <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_tdo   <= '0;
      div           <= '0;
      pcnt          <= '0;
      k             <= '0;
      op            <= '0;
      len           <= '0;
      dat           <= '0;
      cap           <= '0;
      auto_seq      <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (st)
        RESET_SEQ: begin
          st       <= RUN;
          op       <= 2'd0;
          auto_seq <= 1'b1;
          k        <= 8'd6;
          pcnt     <= '0;
          div      <= '0;
          cap      <= '0;
          tms      <= 1'b1;
          tdi      <= 1'b0;
        end
        IDLE, DONE: begin
          st <= IDLE;
          if (accept) begin
            op       <= bus.cmd_op;
            len      <= clen;
            dat      <= bus.cmd_tdi;
            auto_seq <= 1'b0;
            k        <= bus.cmd_op == 2'd0 ? 8'd6 : bus.cmd_op == 2'd1 ? 8'(IR_LENGTH + 6) : {1'b0, clen} + 8'd5;
            pcnt     <= '0;
            div      <= '0;
            cap      <= '0;
            if (bus.cmd_op == 2'd3 || (bus.cmd_op == 2'd2 && clen == 7'd0)) begin
              st            <= DONE;
              bus.rsp_valid <= 1'b1;
              bus.rsp_tdo   <= '0;
            end else begin
              st  <= RUN;
              tms <= 1'b1;
              tdi <= 1'b0;
            end
          end
        end
        RUN: begin
          if (div != DW'(TCK_DIV - 1)) begin
            div <= div + DW'(1);
          end else begin
            div <= '0;
            tck <= ~tck;
            if (!tck) begin
              if (sh_cur) cap <= cap | (MAX_BITS'(tdo) << pi);
            end else if (pcnt == k - 8'd1) begin
              st <= auto_seq ? IDLE : DONE;
              if (!auto_seq) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_tdo   <= cap;
              end
            end else begin
              pcnt <= q;
              tms  <= tms_nxt;
              tdi  <= tdi_nxt;
            end
          end
        end
      endcase
    end
  end
endmodule
